life_stepper: RTL and testbench
===============================

LIFE_STEPPER -- requirements
Module: life_stepper

Interface
REQ-001 SHALL have: clk_130mhz  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start_in  input  1  one-cycle request to compute one generation.
REQ-004 SHALL have: addr_r_out  output  LOG_MAX_ADDR  current-board word read address.
REQ-005 SHALL have: data_r_in  input  WORD_SIZE  read data, valid exactly READ_LATENCY=2 cycles after the address.
REQ-006 SHALL have: addr_w_out  output  LOG_MAX_ADDR  next-board word write address.
REQ-007 SHALL have: data_w_out  output  WORD_SIZE  next-generation word.
REQ-008 SHALL have: we_out  output  1  write strobe, one cycle per word.
REQ-009 SHALL have: busy_out  output  1  high from accepted start until done.
REQ-010 SHALL have: done_out  output  1  one-cycle pulse at generation end.

Function
REQ-011 Board SHALL be BOARD_SIZE x BOARD_SIZE cells, WORDS_PER_ROW = BOARD_SIZE/WORD_SIZE words per row, word address = y*WORDS_PER_ROW + wx.
REQ-012 Cell x SHALL map to bit WORD_SIZE-1-(x mod WORD_SIZE), MSB leftmost, matching the renderer's fetch order.
REQ-013 Read and write boards SHALL be distinct banks selected outside this block; the block never reads a word it wrote in the same generation.
REQ-014 Board edges SHALL wrap toroidally: row -1 is BOARD_SIZE-1, column -1 is BOARD_SIZE-1, both modulo BOARD_SIZE.
REQ-015 Rule SHALL be B3/S23, using a 4-bit neighbour count (0..8).
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, COMPUTE, WRITE, DONE.
REQ-017 IDLE: start_in=1 -> FETCH with word index (y=0, wx=0); start_in is ignored in all other states.
REQ-018 FETCH SHALL last 9 cycles and issue addresses for row offsets dy=-1,0,+1 (outer) by word offsets dwx=-1,0,+1 (inner), with wrap.
REQ-019 DRAIN SHALL last 2 cycles. Returned words are captured into a 3-row x 3-word window in issue order.
REQ-020 COMPUTE SHALL last 1 cycle. Only the LSB of the dwx=-1 word and the MSB of the dwx=+1 word are used as horizontal neighbours. Result is registered.
REQ-021 WRITE SHALL last 1 cycle: we_out=1, addr_w_out = centre word address, data_w_out = result. Then advance wx, and y on wx wrap. Next state is FETCH, or DONE after word (BOARD_SIZE-1, WORDS_PER_ROW-1).
REQ-022 Per-word period SHALL be exactly 13 cycles. A generation SHALL take 13*BOARD_SIZE*WORDS_PER_ROW cycles from start accept to the final write.
REQ-023 DONE SHALL last 1 cycle: done_out=1, busy_out=0, then IDLE.
REQ-024 busy_out SHALL be 1 in FETCH, DRAIN, COMPUTE and WRITE; 0 in IDLE and DONE.
REQ-025 we_out SHALL be 0 in every state except WRITE. addr_r_out holds its last value outside FETCH.
REQ-026 Address arithmetic SHALL use LOG_BOARD_SIZE-bit row and LOG_WORDS_PER_ROW-bit column counters so that wrap is natural overflow.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counters 0, addr_r_out=0, addr_w_out=0, data_w_out=0, we_out=0, busy_out=0, done_out=0.
REQ-028 Reset mid-generation SHALL abort with no further writes. Already-written words remain. The next start_in restarts from word 0.

Structure
REQ-029 WORDS_PER_ROW, LOG_WORDS_PER_ROW, READ_LATENCY and the stepper_state_t enum SHALL live in the shared common package with WORD_SIZE, BOARD_SIZE, LOG_MAX_ADDR and pos_t.
REQ-030 Per-word next-state logic SHALL be one combinational sub-module, life_word_next: three rows of WORD_SIZE+2 bits in, WORD_SIZE bits out.

Verification (bench: BOARD_SIZE=32, WORD_SIZE=16, 64 words, 832 cycles per generation, 2-cycle memory model)
REQ-031 Vertical blinker at x=5, y=4..6, then start -> horizontal blinker at y=5, x=4..6; done_out exactly 833 cycles after start; 64 we_out pulses.
REQ-032 2x2 block at x=15..16, y=10..11 (straddles word boundary) -> unchanged after 3 generations.
REQ-033 Horizontal blinker at y=0, x=31,0,1 (both wraps) -> vertical blinker at x=0, y=31,0,1.
REQ-034 start_in pulsed at cycle 100 of a running generation -> ignored; single done_out; busy_out continuous.
REQ-035 rst_n low at cycle 300 -> all outputs 0 within the same cycle; no we_out until the next start; rerun gives the correct full result.
REQ-036 Empty board -> 64 writes of 16'h0000; fully set board -> 64 writes of 16'h0000 (overpopulation).

Source files
------------

// File: rtl/life_stepper_pkg.sv
// life_stepper_pkg: board geometry, FSM states and address helper shared by
// the life stepper and its per-word next-state logic.
package life_stepper_pkg;

  localparam int WORD_SIZE         = 16;
  localparam int BOARD_SIZE        = 32;
  localparam int LOG_BOARD_SIZE    = $clog2(BOARD_SIZE);
  localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_WORDS_PER_ROW = $clog2(WORDS_PER_ROW);
  localparam int LOG_MAX_ADDR      = LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;
  localparam int READ_LATENCY      = 2;

  typedef struct packed {
    logic [LOG_BOARD_SIZE-1:0]    y;
    logic [LOG_WORDS_PER_ROW-1:0] wx;
  } pos_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    COMPUTE,
    WRITE,
    DONE
  } stepper_state_t;

  // Word address of the neighbour (dr-1, dc-1) of p; wrap is plain overflow.
  function automatic logic [LOG_MAX_ADDR-1:0] word_addr(
    input pos_t       p,
    input logic [1:0] dr,
    input logic [1:0] dc
  );
    logic [LOG_BOARD_SIZE-1:0]    row;
    logic [LOG_WORDS_PER_ROW-1:0] col;
    row = p.y + LOG_BOARD_SIZE'(dr) - LOG_BOARD_SIZE'(1);
    col = p.wx + LOG_WORDS_PER_ROW'(dc) - LOG_WORDS_PER_ROW'(1);
    return {row, col};
  endfunction

endpackage

// File: rtl/life_stepper_word_next.sv
// life_word_next: B3/S23 rule for one word of cells.
// Ports: top/mid/bot rows with one halo cell each side (MSB = left), cells out.
module life_word_next
  import life_stepper_pkg::*;
(
  input  logic [WORD_SIZE+1:0] top,
  input  logic [WORD_SIZE+1:0] mid,
  input  logic [WORD_SIZE+1:0] bot,
  output logic [WORD_SIZE-1:0] cells
);

  // Cell bit i sits at row bit i+1; its neighbours are bits i..i+2.
  for (genvar i = 0; i < WORD_SIZE; i++) begin : g_cell
    logic [3:0] cnt;
    assign cnt = 4'(top[i]) + 4'(top[i+1]) + 4'(top[i+2])
               + 4'(mid[i]) + 4'(mid[i+2])
               + 4'(bot[i]) + 4'(bot[i+1]) + 4'(bot[i+2]);
    assign cells[i] = (cnt == 4'd3) | (mid[i+1] & (cnt == 4'd2));
  end

endmodule

// File: rtl/life_stepper.sv
// life_stepper: computes one Game of Life generation, word by word, from a
// read bank into a write bank on a toroidal board.
// Ports: clk_130mhz, rst_n (async low), start_in -> busy_out, done_out;
// read port addr_r_out/data_r_in; write port addr_w_out/data_w_out/we_out.
module life_stepper
  import life_stepper_pkg::*;
(
  input  logic                    clk_130mhz,
  input  logic                    rst_n,
  input  logic                    start_in,
  output logic [LOG_MAX_ADDR-1:0] addr_r_out,
  input  logic [WORD_SIZE-1:0]    data_r_in,
  output logic [LOG_MAX_ADDR-1:0] addr_w_out,
  output logic [WORD_SIZE-1:0]    data_w_out,
  output logic                    we_out,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int WIN_W = 9 * WORD_SIZE;
  localparam int R0    = WIN_W - WORD_SIZE;
  localparam int R1    = R0 - 3 * WORD_SIZE;
  localparam int R2    = R1 - 3 * WORD_SIZE;
  localparam int DW    = $clog2(READ_LATENCY);

  stepper_state_t          state;
  pos_t                    pos;
  pos_t                    pos_nxt;
  logic [1:0]              dr;
  logic [1:0]              dc;
  logic [1:0]              nr;
  logic [1:0]              nc;
  logic [DW-1:0]           drain_cnt;
  logic [READ_LATENCY-1:0] vld;
  logic [WIN_W-1:0]        win;
  logic [WORD_SIZE-1:0]    next_word;
  logic                    last;

  // Window holds 9 words in issue order, oldest (dy=-1,dwx=-1) at the top.
  // Each row's left-word LSB, centre word and right-word MSB are contiguous.
  life_word_next u_next (
    .top   (win[R0 -: WORD_SIZE+2]),
    .mid   (win[R1 -: WORD_SIZE+2]),
    .bot   (win[R2 -: WORD_SIZE+2]),
    .cells (next_word)
  );

  logic unused_win;
  assign unused_win = ^win[WIN_W-1:R0+1];

  assign nc   = (dc == 2'd2) ? 2'd0 : dc + 2'd1;
  assign nr   = (dc == 2'd2) ? dr + 2'd1 : dr;
  assign last = (&pos.y) & (&pos.wx);

  always_comb begin
    pos_nxt    = pos;
    pos_nxt.wx = pos.wx + LOG_WORDS_PER_ROW'(1);
    if (&pos.wx)
      pos_nxt.y = pos.y + LOG_BOARD_SIZE'(1);
  end

  always_ff @(posedge clk_130mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos        <= pos_t'('0);
      dr         <= '0;
      dc         <= '0;
      drain_cnt  <= '0;
      vld        <= '0;
      win        <= '0;
      addr_r_out <= '0;
      addr_w_out <= '0;
      data_w_out <= '0;
      we_out     <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      we_out   <= 1'b0;
      done_out <= 1'b0;
      // Issue-valid delayed by the read latency marks returning data.
      vld <= {vld[READ_LATENCY-2:0], state == FETCH};
      if (vld[READ_LATENCY-1])
        win <= {win[WIN_W-WORD_SIZE-1:0], data_r_in};
      unique case (state)
        IDLE: begin
          if (start_in) begin
            state      <= FETCH;
            pos        <= pos_t'('0);
            dr         <= '0;
            dc         <= '0;
            addr_r_out <= word_addr(pos_t'('0), 2'd0, 2'd0);
            busy_out   <= 1'b1;
          end
        end
        FETCH: begin
          if (dr == 2'd2 && dc == 2'd2) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            dr         <= nr;
            dc         <= nc;
            addr_r_out <= word_addr(pos, nr, nc);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(READ_LATENCY - 1))
            state <= COMPUTE;
          else
            drain_cnt <= drain_cnt + DW'(1);
        end
        COMPUTE: begin
          state      <= WRITE;
          we_out     <= 1'b1;
          addr_w_out <= pos;
          data_w_out <= next_word;
        end
        WRITE: begin
          if (last) begin
            state    <= DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else begin
            state      <= FETCH;
            pos        <= pos_nxt;
            dr         <= '0;
            dc         <= '0;
            addr_r_out <= word_addr(pos_nxt, 2'd0, 2'd0);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_stepper.sv
// tb_life_stepper: directed scenarios for life_stepper on a 32x32 board
// with a two-cycle registered read memory and a separate write bank.
module tb_life_stepper;
  import life_stepper_pkg::*;

  localparam int NW = BOARD_SIZE * WORDS_PER_ROW;

  logic                    clk_130mhz = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    start_in = 1'b0;
  logic [LOG_MAX_ADDR-1:0] addr_r_out;
  logic [WORD_SIZE-1:0]    data_r_in;
  logic [LOG_MAX_ADDR-1:0] addr_w_out;
  logic [WORD_SIZE-1:0]    data_w_out;
  logic                    we_out;
  logic                    busy_out;
  logic                    done_out;

  logic [WORD_SIZE-1:0] mem [NW];
  logic [WORD_SIZE-1:0] nxt [NW];
  logic [WORD_SIZE-1:0] exp_b [NW];
  logic [WORD_SIZE-1:0] p1;

  int asserts = 0;
  int fails = 0;

  life_stepper dut (
    .clk_130mhz (clk_130mhz),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .addr_r_out (addr_r_out),
    .data_r_in  (data_r_in),
    .addr_w_out (addr_w_out),
    .data_w_out (data_w_out),
    .we_out     (we_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #4 clk_130mhz = ~clk_130mhz;

  always @(posedge clk_130mhz) begin
    p1        <= mem[addr_r_out];
    data_r_in <= p1;
  end

  task automatic clear_boards();
    for (int i = 0; i < NW; i++) begin
      mem[i]   = '0;
      exp_b[i] = '0;
      nxt[i]   = 16'hA5A5;
    end
  endtask

  task automatic put_cell(input int x, input int y);
    mem[y*WORDS_PER_ROW + x/WORD_SIZE][WORD_SIZE-1-(x%WORD_SIZE)] = 1'b1;
  endtask

  task automatic exp_cell(input int x, input int y);
    exp_b[y*WORDS_PER_ROW + x/WORD_SIZE][WORD_SIZE-1-(x%WORD_SIZE)] = 1'b1;
  endtask

  task automatic next_gen();
    for (int i = 0; i < NW; i++) begin
      mem[i] = nxt[i];
      nxt[i] = 16'hA5A5;
    end
  endtask

  function automatic int board_diff();
    int d = 0;
    for (int i = 0; i < NW; i++)
      if (nxt[i] !== exp_b[i]) d++;
    return d;
  endfunction

  task automatic run_gen(input int pulse_at, output int cyc,
                         output int dones, output int gap,
                         output int wr, output logic busy_at_done);
    int n = 0;
    wr = 0;
    gap = 0;
    dones = 0;
    @(negedge clk_130mhz);
    start_in = 1'b1;
    do begin
      @(posedge clk_130mhz);
      n++;
      #1;
      start_in = (n == pulse_at);
      if (we_out) begin
        nxt[addr_w_out] = data_w_out;
        wr++;
      end
      if (!done_out && !busy_out) gap++;
    end while (!done_out && n < 2000);
    cyc = n;
    busy_at_done = busy_out;
    if (done_out) dones = 1;
    repeat (4) begin
      @(posedge clk_130mhz);
      #1;
      if (done_out) dones++;
      if (we_out) wr++;
    end
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    asserts++;
    if ({we_out, busy_out, done_out} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000",
               {we_out, busy_out, done_out});
    end
    asserts++;
    if ({addr_r_out, addr_w_out, data_w_out} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0",
               addr_r_out, addr_w_out, data_w_out);
    end
    repeat (2) @(posedge clk_130mhz);
    @(negedge clk_130mhz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_130mhz);
  endtask

  task automatic test_blinker();
    int cyc, dones, gap, wr, d;
    logic bd;
    clear_boards();
    put_cell(5, 4); put_cell(5, 5); put_cell(5, 6);
    exp_cell(4, 5); exp_cell(5, 5); exp_cell(6, 5);
    run_gen(0, cyc, dones, gap, wr, bd);
    asserts++;
    if (cyc !== 833) begin
      fails++;
      $display("FAIL blinker_latency: got %0d want 833", cyc);
    end
    asserts++;
    if (wr !== 64) begin
      fails++;
      $display("FAIL blinker_writes: got %0d want 64", wr);
    end
    d = board_diff();
    asserts++;
    if (d !== 0) begin
      fails++;
      $display("FAIL blinker_board: got %0d bad words want 0", d);
    end
    asserts++;
    if (dones !== 1) begin
      fails++;
      $display("FAIL blinker_done: got %0d pulses want 1", dones);
    end
    asserts++;
    if (gap !== 0 || bd !== 1'b0) begin
      fails++;
      $display("FAIL blinker_busy: got gap %0d busy@done %b want 0 0",
               gap, bd);
    end
  endtask

  task automatic test_block();
    int cyc, dones, gap, wr, d;
    logic bd;
    clear_boards();
    put_cell(15, 10); put_cell(16, 10); put_cell(15, 11); put_cell(16, 11);
    exp_cell(15, 10); exp_cell(16, 10); exp_cell(15, 11); exp_cell(16, 11);
    for (int g = 0; g < 3; g++) begin
      if (g > 0) next_gen();
      run_gen(0, cyc, dones, gap, wr, bd);
      d = board_diff();
      asserts++;
      if (d !== 0) begin
        fails++;
        $display("FAIL block_gen%0d: got %0d bad words want 0", g, d);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, dones, gap, wr, d;
    logic bd;
    clear_boards();
    put_cell(31, 0); put_cell(0, 0); put_cell(1, 0);
    exp_cell(0, 31); exp_cell(0, 0); exp_cell(0, 1);
    run_gen(0, cyc, dones, gap, wr, bd);
    d = board_diff();
    asserts++;
    if (d !== 0) begin
      fails++;
      $display("FAIL wrap_board: got %0d bad words want 0", d);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, dones, gap, wr, d;
    logic bd;
    clear_boards();
    put_cell(5, 4); put_cell(5, 5); put_cell(5, 6);
    exp_cell(4, 5); exp_cell(5, 5); exp_cell(6, 5);
    run_gen(100, cyc, dones, gap, wr, bd);
    asserts++;
    if (cyc !== 833 || dones !== 1) begin
      fails++;
      $display("FAIL restart_done: got %0d cyc %0d pulses want 833 1",
               cyc, dones);
    end
    asserts++;
    if (gap !== 0 || wr !== 64) begin
      fails++;
      $display("FAIL restart_busy: got gap %0d writes %0d want 0 64",
               gap, wr);
    end
    d = board_diff();
    asserts++;
    if (d !== 0) begin
      fails++;
      $display("FAIL restart_board: got %0d bad words want 0", d);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, dones, gap, wr, d, late;
    logic bd;
    clear_boards();
    put_cell(5, 4); put_cell(5, 5); put_cell(5, 6);
    exp_cell(4, 5); exp_cell(5, 5); exp_cell(6, 5);
    wr = 0;
    @(negedge clk_130mhz);
    start_in = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk_130mhz);
      #1;
      start_in = 1'b0;
      if (we_out) begin
        nxt[addr_w_out] = data_w_out;
        wr++;
      end
    end
    asserts++;
    if (wr !== 23) begin
      fails++;
      $display("FAIL abort_partial: got %0d writes want 23", wr);
    end
    #1 rst_n = 1'b0;
    #1;
    asserts++;
    if ({we_out, busy_out, done_out} !== 3'b000 ||
        {addr_r_out, addr_w_out, data_w_out} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got %b %h/%h/%h want 000 0/0/0",
               {we_out, busy_out, done_out},
               addr_r_out, addr_w_out, data_w_out);
    end
    repeat (3) @(posedge clk_130mhz);
    @(negedge clk_130mhz);
    rst_n = 1'b1;
    late = 0;
    repeat (20) begin
      @(posedge clk_130mhz);
      #1;
      if (we_out || busy_out) late++;
    end
    asserts++;
    if (late !== 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", late);
    end
    run_gen(0, cyc, dones, gap, wr, bd);
    d = board_diff();
    asserts++;
    if (d !== 0 || wr !== 64) begin
      fails++;
      $display("FAIL abort_rerun: got %0d bad words %0d writes want 0 64",
               d, wr);
    end
  endtask

  task automatic test_empty_full();
    int cyc, dones, gap, wr, d;
    logic bd;
    clear_boards();
    run_gen(0, cyc, dones, gap, wr, bd);
    d = board_diff();
    asserts++;
    if (d !== 0 || wr !== 64) begin
      fails++;
      $display("FAIL empty_board: got %0d bad words %0d writes want 0 64",
               d, wr);
    end
    clear_boards();
    for (int i = 0; i < NW; i++) mem[i] = '1;
    run_gen(0, cyc, dones, gap, wr, bd);
    d = board_diff();
    asserts++;
    if (d !== 0 || wr !== 64) begin
      fails++;
      $display("FAIL full_board: got %0d bad words %0d writes want 0 64",
               d, wr);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_empty_full();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
